// File: rtl/pcx_max_arb.sv
// Two-core PCX arbiter feeding the Maxeler link: grants one packet at a time
// (round-robin, atomic pairs locked to one core) and serializes it MSW-first.
module pcx_max_arb #(
  parameter int PCX_W   = 124,
  parameter int MAX_D_W = 32
) (
  input  logic               gclk,
  input  logic               reset_l,
  input  logic               req0_valid,
  input  logic [PCX_W-1:0]   req0_data,
  input  logic               req0_atom,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [PCX_W-1:0]   req1_data,
  input  logic               req1_atom,
  output logic               req1_ready,
  input  logic               max_pcx_stall,
  output logic               max_pcx_valid,
  output logic [MAX_D_W-1:0] max_pcx_data,
  output logic               max_pcx_sop,
  output logic               max_pcx_src,
  output logic [15:0]        pkt_cnt
);

  localparam int PKT_W = 4 * MAX_D_W;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         widx;
  logic               rr;
  logic               lock;
  logic               lock_id;
  logic               atom;
  logic               src;
  logic [PKT_W-1:0]   pkt;
  logic [PKT_W-1:0]   pkt_sh;

  logic               gnt_vld;
  logic               gnt_id;
  logic               consume;
  logic               last_word;

  // Grant selection; gated by reset so every output reads 0 while held in reset.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (reset_l && state == IDLE) begin
      if (lock) begin
        gnt_id  = lock_id;
        gnt_vld = lock_id ? req1_valid : req0_valid;
      end else if (req0_valid && req1_valid) begin
        gnt_id  = rr;
        gnt_vld = 1'b1;
      end else if (req0_valid) begin
        gnt_id  = 1'b0;
        gnt_vld = 1'b1;
      end else if (req1_valid) begin
        gnt_id  = 1'b1;
        gnt_vld = 1'b1;
      end
    end
  end

  assign req0_ready = gnt_vld & ~gnt_id;
  assign req1_ready = gnt_vld &  gnt_id;

  assign consume   = (state == SEND) & ~max_pcx_stall;
  assign last_word = consume & (widx == 2'd3);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (gnt_vld)   state_nxt = SEND;
      SEND: if (last_word) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Packet capture and word sequencing
  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      widx    <= 2'd0;
      rr      <= 1'b0;
      lock    <= 1'b0;
      lock_id <= 1'b0;
      atom    <= 1'b0;
      src     <= 1'b0;
      pkt     <= '0;
      pkt_cnt <= 16'd0;
    end else begin
      if (state == IDLE && gnt_vld) begin
        pkt  <= gnt_id ? PKT_W'(req1_data) : PKT_W'(req0_data);
        atom <= gnt_id ? req1_atom : req0_atom;
        src  <= gnt_id;
        widx <= 2'd0;
      end else if (consume) begin
        widx <= widx + 2'd1;
      end

      // Completion: atomic first halves pin the next grant to the same core.
      if (last_word) begin
        pkt_cnt <= pkt_cnt + 16'd1;
        if (atom) begin
          lock    <= 1'b1;
          lock_id <= src;
        end else begin
          lock <= 1'b0;
          rr   <= ~src;
        end
      end
    end
  end

  assign pkt_sh        = pkt << (widx * MAX_D_W);
  assign max_pcx_data  = pkt_sh[PKT_W-1 -: MAX_D_W];
  assign max_pcx_valid = (state == SEND);
  assign max_pcx_sop   = (state == SEND) && (widx == 2'd0);
  assign max_pcx_src   = src;

endmodule

// File: doc/pcx_max_arb.md
PCX_MAX_ARB -- requirements
Module: pcx_max_arb

Interface
REQ-001 Parameter PCX_W, default 124, PCX packet width.
REQ-002 Parameter MAX_D_W, default 32, Maxeler PCX word width.
REQ-003 gclk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset_l  in  1  reset, asynchronous, active-low.
REQ-005 req0_valid  in  1  core 0 has a PCX packet pending.
REQ-006 req0_data  in  PCX_W  core 0 packet.
REQ-007 req0_atom  in  1  core 0 packet is first half of an atomic pair.
REQ-008 req0_ready  out  1  core 0 packet accepted this cycle.
REQ-009 req1_valid, req1_data, req1_atom, req1_ready: same as REQ-005..008, for core 1.
REQ-010 max_pcx_stall  in  1  Maxeler PCX link cannot accept a word this cycle.
REQ-011 max_pcx_valid  out  1  word on max_pcx_data is valid.
REQ-012 max_pcx_data  out  MAX_D_W  serialized packet word.
REQ-013 max_pcx_sop  out  1  current word is word 0 of a packet.
REQ-014 max_pcx_src  out  1  core ID of the packet being sent.
REQ-015 pkt_cnt  out  16  packets fully sent, mod 2^16.

Function
REQ-016 States: IDLE, SEND; 2-bit word index widx; 1-bit round-robin pointer rr; lock flag and lock_id.
REQ-017 In IDLE with lock=0: if exactly one reqN_valid, grant N; if both, grant rr; if none, stay IDLE.
REQ-018 In IDLE with lock=1: grant only lock_id when its valid is high; the other requester is ignored even if valid.
REQ-019 reqN_ready is combinational, high only in IDLE for the granted requester; at most one ready high per cycle.
REQ-020 On accept (valid&ready): latch pkt = {4'b0, reqN_data} (128 bits), atom bit and src=N; go to SEND, widx=0.
REQ-021 SEND: max_pcx_valid=1; max_pcx_data = pkt[127-32*widx -: 32] (MSW first); max_pcx_sop = (widx==0).
REQ-022 A word is consumed when max_pcx_valid=1 and max_pcx_stall=0 in the same cycle; widx then increments.
REQ-023 While stall=1: data, sop, src and widx held stable; no word is lost or duplicated.
REQ-024 Consuming widx=3: pkt_cnt increments (wrap 0xFFFF->0x0000); return to IDLE.
REQ-025 Packet completes with atom=1: lock=1, lock_id=src; rr unchanged.
REQ-026 Packet completes with atom=0: lock=0; rr = ~src.
REQ-027 Latency: packet accepted cycle N -> word 0 valid cycle N+1; minimum 5 cycles per packet (1 accept + 4 words).
REQ-028 max_pcx_valid=0 and max_pcx_sop=0 in IDLE; max_pcx_data is don't-care when valid=0 but is driven from pkt (no X).
REQ-029 Requester-side inputs are ignored in SEND; dropping reqN_valid after accept has no effect on the sent packet.

Reset
REQ-030 reset_l=0 asynchronously forces IDLE, widx=0, rr=0, lock=0, lock_id=0, pkt=0, src=0, pkt_cnt=0; all outputs 0.
REQ-031 Reset mid-SEND abandons the partial packet; pkt_cnt is not incremented; the first post-reset word is sop=1 of a new packet.
REQ-032 First grant after reset with both valid goes to core 0.

Verification
REQ-033 Single packet: req0 data=124'h…A5 (low 32 bits 0x000000A5), no stall -> ready cycle N; words N+1..N+4, word 3 = 0x000000A5, sop only at N+1, src=0, pkt_cnt=1.
REQ-034 Both valid continuously, atom=0 -> grants alternate 0,1,0,1; pkt_cnt=4 after 20 cycles.
REQ-035 req0 atom=1 then atom=0, req1 valid throughout -> two core-0 packets back-to-back, then core 1.
REQ-036 Stall held high 3 cycles at widx=2 -> word 2 held for 4 cycles, exactly 4 consumed words total.
REQ-037 reset_l pulsed low during widx=1 -> outputs 0 immediately, pkt_cnt unchanged at 0, next packet starts sop=1.
REQ-038 pkt_cnt preloaded via 65535 packets -> next completion reads 0x0000.
